sqrt_sched: RTL and testbench
=============================

Name: sqrt_sched

Overview:
Round-robin scheduler that shares one successive-approximation square-root engine among NREQ requesters. It arbitrates requests, captures the winning operand and drives the engine's start pulse. It then waits for the engine's done pulse, with a timeout, and returns the tagged result over a valid/ready response port. It sits between the client blocks and a single root engine with an X/Q/st/ok interface.

Parameters:
NREQ, 4, number of requesters (2..16)
QW, 27, engine result width; operand width XW = 2*QW (localparam)
TIMEOUT, 64, max WAIT cycles before declaring engine failure (must exceed QW+1)
IW, $clog2(NREQ), requester id width (localparam)

Ports:
clk  in  1  system clock, all state on posedge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
req_valid  in  NREQ  per-requester request valid
req_x  in  NREQ*XW  packed operands; requester k at bits [k*XW +: XW]
req_ready  out  NREQ  one-hot accept, at most one bit high
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_id  out  IW  requester index of the result
rsp_q  out  QW  floor(sqrt(x)), 0 on error
rsp_err  out  1  1 = engine timeout
sq_x  out  XW  operand to engine, held stable from START through WAIT
sq_st  out  1  one-cycle engine start pulse
sq_ok  in  1  engine one-cycle done pulse; sq_q valid while high
sq_q  in  QW  engine result
busy  out  1  state != IDLE
done_cnt  out  16  completed responses, wraps at 0xFFFF->0
tmo_cnt  out  8  timeouts, saturates at 0xFF

Behaviour:
- Reset (async, rst_n=0): state=IDLE; last_grant=NREQ-1; sq_st=0; sq_x=0; rsp_valid=0; rsp_id=0; rsp_q=0; rsp_err=0; counters=0; req_ready=0.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - Arbitrate among req_valid, searching from last_grant+1 upward modulo NREQ.
  - Winner g gets req_ready[g]=1 combinationally in the same cycle; req_ready is 0 in all other states.
  - On that edge: sq_x<=req_x[g], id<=g, state<=START.
  - No request: stay in IDLE.
- START: sq_st=1 for exactly this cycle; timer<=0; ->WAIT.
- WAIT:
  - sq_ok=1: rsp_q<=sq_q, rsp_err<=0, ->RESP.
  - Else if timer==TIMEOUT-1: rsp_q<=0, rsp_err<=1, tmo_cnt++ (saturating), ->RESP.
  - Else timer++.
  - If sq_ok and the timeout coincide, sq_ok wins.
- RESP:
  - rsp_valid=1; rsp_id/rsp_q/rsp_err stable until handshake.
  - On rsp_valid&&rsp_ready: done_cnt++, last_grant<=id, ->IDLE.
  - A new grant is possible in the cycle after the handshake, not the same cycle.
- sq_ok is ignored in IDLE, START and RESP; a stray pulse has no effect.
- Engine latency with QW=27: sq_ok is high 27 cycles after the edge that samples sq_st=1. Best-case request-to-rsp_valid is 1+1+27+1 cycles.
- sq_x is held unchanged from capture until the next grant, so the engine's comparison input stays stable.
- Reset mid-operation: all state is discarded. A later engine sq_ok is ignored in IDLE. The next START restarts the engine, because its start has priority.
- A requester dropping req_valid before being granted is legal; it is never granted for that request.
- Fairness: under continuous requests from all requesters, grants rotate 0,1,2,...,NREQ-1,0,...

Decomposition:
- Shared package/include sqrt_sched_pkg:
  - state encoding constants S_IDLE=0, S_START=1, S_WAIT=2, S_RESP=3;
  - default QW, TIMEOUT;
  - XW derivation.
- One sub-module rr_arbiter (NREQ-wide, inputs req and last_grant, outputs one-hot grant and encoded index), purely combinational. The FSM, timer and counters live in sqrt_sched.

Test Plan:
- Single request: req 0 with x=144 and a behavioural engine (QW=27) -> req_ready[0] for one cycle; sq_st one pulse with sq_x=144; rsp_valid 30 cycles after grant; rsp_id=0, rsp_q=12, rsp_err=0; done_cnt=1.
- All four requesters with x=0,1,2^53-1,10^6 held valid -> grant order 0,1,2,3; results 0,1,94906265,1000; no overlapping sq_st pulses.
- Engine never asserts sq_ok -> rsp_err=1, rsp_q=0 after TIMEOUT=64 WAIT cycles; tmo_cnt=1; the next request completes normally.
- rsp_ready held low 10 cycles -> rsp_valid, rsp_id and rsp_q stable throughout; no grant until the handshake; grant one cycle after.
- rst_n pulsed low mid-WAIT, then a stray sq_ok -> all outputs return to reset values immediately; the stray pulse is ignored; the next request gives a correct result.
- sq_ok on the same cycle timer reaches TIMEOUT-1 -> rsp_err=0 with the engine result; tmo_cnt unchanged.

Source files
------------

// File: rtl/sqrt_sched_pkg.sv
// Shared definitions for the square-root engine scheduler: FSM encoding,
// default engine geometry and the operand-width derivation.
package sqrt_sched_pkg;

  localparam int QW_DEF      = 27;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // Operand is twice the root width so the full result range is reachable.
  function automatic int xw_of(input int qw);
    return 2 * qw;
  endfunction

endpackage

// File: rtl/sqrt_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the nearest requester above last_i
// (wrapping modulo NREQ) wins.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            vld_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    // Walk farthest-first so the closest requesting slot is written last.
    for (int k = NREQ; k >= 1; k--) begin
      int p;
      p = (int'(last_i) + k) % NREQ;
      if (req_i[p]) begin
        vld_o = 1'b1;
        idx_o = p[IW-1:0];
      end
    end
    gnt_o[idx_o] = vld_o;
  end

endmodule

// File: rtl/sqrt_sched.sv
// Shares one successive-approximation square-root engine among NREQ
// requesters, with engine timeout and a tagged valid/ready response.
module sqrt_sched
  import sqrt_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int QW      = QW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  localparam int XW     = xw_of(QW),
  localparam int IW     = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*XW-1:0] req_x,
  output logic [NREQ-1:0]  req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IW-1:0]    rsp_id,
  output logic [QW-1:0]    rsp_q,
  output logic             rsp_err,
  output logic [XW-1:0]    sq_x,
  output logic             sq_st,
  input  logic             sq_ok,
  input  logic [QW-1:0]    sq_q,
  output logic             busy,
  output logic [15:0]      done_cnt,
  output logic [7:0]       tmo_cnt
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e          state_q;
  logic [IW-1:0]   last_q, id_q;
  logic [TW-1:0]   timer_q;
  logic [XW-1:0]   sq_x_q;
  logic            sq_st_q, rsp_valid_q, rsp_err_q;
  logic [QW-1:0]   rsp_q_q;
  logic [15:0]     done_cnt_q;
  logic [7:0]      tmo_cnt_q;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_vld;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req_i  (req_valid),
    .last_i (last_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .vld_o  (arb_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_q      <= IW'(NREQ - 1);
      id_q        <= '0;
      timer_q     <= '0;
      sq_x_q      <= '0;
      sq_st_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_q_q     <= '0;
      done_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      sq_st_q <= 1'b0;
      case (state_q)
        S_IDLE: if (arb_vld) begin
          sq_x_q  <= req_x[int'(arb_idx)*XW +: XW];
          id_q    <= arb_idx;
          sq_st_q <= 1'b1;
          state_q <= S_START;
        end
        S_START: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A done pulse on the final timer cycle still counts as success.
          if (sq_ok) begin
            rsp_q_q     <= sq_q;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            rsp_q_q     <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            if (tmo_cnt_q != 8'hFF) tmo_cnt_q <= tmo_cnt_q + 8'd1;
            state_q     <= S_RESP;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          done_cnt_q  <= done_cnt_q + 16'd1;
          last_q      <= id_q;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE) ? arb_gnt : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_q     = rsp_q_q;
  assign rsp_err   = rsp_err_q;
  assign sq_x      = sq_x_q;
  assign sq_st     = sq_st_q;
  assign busy      = (state_q != S_IDLE);
  assign done_cnt  = done_cnt_q;
  assign tmo_cnt   = tmo_cnt_q;

endmodule

// File: tb/tb_sqrt_sched.sv
// Directed and randomized bench for sqrt_sched with a behavioural root engine.
module tb_sqrt_sched;

  localparam int NREQ = 4;
  localparam int QW   = 27;
  localparam int XW   = 2 * QW;
  localparam int IW   = 2;
  localparam int TO   = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*XW-1:0] req_x;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid, rsp_ready = 1'b0;
  logic [IW-1:0]     rsp_id;
  logic [QW-1:0]     rsp_q;
  logic              rsp_err;
  logic [XW-1:0]     sq_x;
  logic              sq_st, sq_ok;
  logic [QW-1:0]     sq_q;
  logic              busy;
  logic [15:0]       done_cnt;
  logic [7:0]        tmo_cnt;

  logic [XW-1:0] xs [NREQ];

  int n_chk = 0, n_pass = 0;
  int m_last = NREQ - 1, m_done = 0, m_tmo = 0;

  // Engine model: result appears eng_lat cycles after the edge that sees sq_st.
  int          eng_lat = QW;
  bit          eng_dead = 1'b0;
  bit          eng_act = 1'b0;
  int          eng_cnt = 0;
  logic [XW-1:0] eng_x = '0;
  logic        eng_ok = 1'b0;
  logic [QW-1:0] eng_res = '0;

  sqrt_sched #(.NREQ(NREQ), .QW(QW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x(req_x),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_err(rsp_err), .sq_x(sq_x),
    .sq_st(sq_st), .sq_ok(sq_ok), .sq_q(sq_q), .busy(busy),
    .done_cnt(done_cnt), .tmo_cnt(tmo_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_x = '0;
    for (int k = 0; k < NREQ; k++) req_x[k*XW +: XW] = xs[k];
  end

  function automatic logic [QW-1:0] isqrt(input longint unsigned x);
    longint unsigned lo, hi, mid;
    lo = 0; hi = 64'd1 << QW;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= x) lo = mid; else hi = mid;
    end
    return lo[QW-1:0];
  endfunction

  always @(posedge clk) begin
    eng_ok <= 1'b0;
    if (sq_st) begin
      eng_act <= 1'b1;
      eng_cnt <= 0;
      eng_x   <= sq_x;
    end else if (eng_act) begin
      eng_cnt <= eng_cnt + 1;
      if (!eng_dead && eng_cnt + 1 == eng_lat) begin
        eng_ok  <= 1'b1;
        eng_res <= isqrt(64'(eng_x));
        eng_act <= 1'b0;
      end
    end
  end
  assign sq_ok = eng_ok;
  assign sq_q  = eng_res;

  function automatic int pick(input logic [NREQ-1:0] m, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (m[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    m_last = NREQ - 1; m_done = 0; m_tmo = 0;
  endtask

  // Serve one request end to end; exp_wait<0 skips the grant-latency check.
  task automatic run_one(input string tag, input int exp_id, input logic [QW-1:0] exp_q,
                         input logic exp_err, input int exp_lat, input int hold,
                         input int exp_wait);
    int w, k;
    bit bad;
    logic [XW-1:0] gx;
    #1;
    w = 0;
    while (req_ready == '0 && w < 300) begin tick(); #1; w++; end
    chk({tag, " grant"}, 64'(req_ready), 64'(1) << exp_id);
    if (exp_wait >= 0) chk({tag, " grant_wait"}, 64'(w), 64'(exp_wait));
    gx = xs[exp_id];
    tick();
    req_valid[exp_id] = 1'b0;
    chk({tag, " sq_st"}, 64'(sq_st), 64'd1);
    chk({tag, " sq_x"}, 64'(sq_x), 64'(gx));
    k = 1; bad = 1'b0;
    while (!rsp_valid && k < 400) begin
      tick(); k++;
      if (sq_st || req_ready != '0 || sq_x != gx) bad = 1'b1;
    end
    chk({tag, " latency"}, 64'(k), 64'(exp_lat));
    chk({tag, " quiet_wait"}, 64'(bad), 64'd0);
    chk({tag, " rsp_id"}, 64'(rsp_id), 64'(exp_id));
    chk({tag, " rsp_q"}, 64'(rsp_q), 64'(exp_q));
    chk({tag, " rsp_err"}, 64'(rsp_err), 64'(exp_err));
    if (hold > 0) begin
      bad = 1'b0;
      repeat (hold) begin
        tick();
        if (!rsp_valid || rsp_id != IW'(exp_id) || rsp_q != exp_q || rsp_err != exp_err
            || req_ready != '0) bad = 1'b1;
      end
      chk({tag, " hold_stable"}, 64'(bad), 64'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    m_done++; m_last = exp_id;
    if (exp_err && m_tmo < 255) m_tmo++;
    chk({tag, " rsp_valid_low"}, 64'(rsp_valid), 64'd0);
    chk({tag, " done_cnt"}, 64'(done_cnt), 64'(m_done));
    chk({tag, " tmo_cnt"}, 64'(tmo_cnt), 64'(m_tmo));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, " rsp_id"}, 64'(rsp_id), 64'd0);
    chk({tag, " rsp_q"}, 64'(rsp_q), 64'd0);
    chk({tag, " rsp_err"}, 64'(rsp_err), 64'd0);
    chk({tag, " sq_st"}, 64'(sq_st), 64'd0);
    chk({tag, " sq_x"}, 64'(sq_x), 64'd0);
    chk({tag, " done_cnt"}, 64'(done_cnt), 64'd0);
    chk({tag, " tmo_cnt"}, 64'(tmo_cnt), 64'd0);
    chk({tag, " req_ready"}, 64'(req_ready), 64'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int id, w, exp_w;
    bit bad;
    logic [NREQ-1:0] m;
    for (int k = 0; k < NREQ; k++) xs[k] = '0;

    // Reset values
    #3;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single request, best-case latency
    xs[0] = 54'd144;
    req_valid = 4'b0001;
    run_one("single", 0, 27'd12, 1'b0, 30, 0, 0);

    // All four requesters from a fresh reset rotate 0,1,2,3
    pulse_reset();
    tick();
    xs[0] = 54'd0; xs[1] = 54'd1; xs[2] = (54'd1 << 53) - 54'd1; xs[3] = 54'd1000000;
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      id = pick(req_valid, m_last);
      chk("rotate order", 64'(id), 64'(i));
      run_one("rotate", id, isqrt(64'(xs[id])), 1'b0, 30, 0, 0);
    end
    chk("rotate q2", 64'(isqrt(64'(xs[2]))), 64'd94906265);

    // Engine never answers -> timeout, then a normal request
    eng_dead = 1'b1;
    xs[2] = 54'd81;
    req_valid = 4'b0100;
    run_one("timeout", 2, 27'd0, 1'b1, TO + 2, 0, 0);
    eng_dead = 1'b0;
    xs[1] = 54'd50;
    req_valid = 4'b0010;
    run_one("after_tmo", 1, 27'd7, 1'b0, 30, 0, 0);

    // Backpressure: no new grant until handshake, grant the very next cycle
    xs[1] = 54'd99; xs[3] = 54'd4096;
    req_valid = 4'b1010;
    id = pick(req_valid, m_last);
    run_one("hold", id, isqrt(64'(xs[id])), 1'b0, 30, 10, 0);
    id = pick(req_valid, m_last);
    run_one("hold_next", id, isqrt(64'(xs[id])), 1'b0, 30, 0, 0);

    // Done pulse on the last timer cycle wins over the timeout
    eng_lat = TO - 1;
    xs[0] = 54'd1234567;
    req_valid = 4'b0001;
    run_one("coincide", 0, isqrt(64'd1234567), 1'b0, TO + 2, 0, 0);
    eng_lat = QW;

    // Reset mid-WAIT; later stray done pulse must be ignored
    xs[2] = 54'd400;
    req_valid = 4'b0100;
    #1;
    w = 0;
    while (req_ready == '0 && w < 50) begin tick(); #1; w++; end
    chk("midrst grant", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_idle_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (40) begin tick(); if (busy || rsp_valid || sq_st) bad = 1'b1; end
    chk("stray_ignored", 64'(bad), 64'd0);
    xs[3] = 54'd10000;
    req_valid = 4'b1000;
    run_one("post_rst", 3, 27'd100, 1'b0, 30, 0, 0);

    // Randomized batches served in round-robin order
    for (int r = 0; r < 6; r++) begin
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int k = 0; k < NREQ; k++)
        if (m[k]) xs[k] = XW'({$urandom(), $urandom()});
      req_valid = m;
      exp_w = 0;
      while (req_valid != '0) begin
        id = pick(req_valid, m_last);
        run_one("random", id, isqrt(64'(xs[id])), 1'b0, 30, int'($urandom_range(0, 2)), exp_w);
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
